// File: rtl/frame_display_reader_pkg.sv
// Shared types and default geometry for the processed-image display reader:
// RGB444 pixel type, default image size and 640x480 VGA timing.
package frame_display_reader_pkg;

   localparam int PIX_W = 12;
   typedef logic [PIX_W-1:0] rgb444_t;

   localparam rgb444_t RGB_BLACK = 12'h000;
   localparam rgb444_t RGB_WHITE = 12'hFFF;

   localparam int IMG_W_DEF      = 400;
   localparam int IMG_H_DEF      = 300;
   localparam int IMG_PIXELS_DEF = IMG_W_DEF * IMG_H_DEF;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;

   function automatic int line_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   localparam int H_TOTAL_DEF = line_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
   localparam int V_TOTAL_DEF = line_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } rd_state_t;

endpackage

// File: rtl/frame_display_reader_timing.sv
// video_timing_gen: raster h/v counters with sync, active and frame-end flags.
// Counters advance on tick and are held at zero while hold is high.
module video_timing_gen
   import frame_display_reader_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF,
   parameter int HW       = $clog2(line_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
   parameter int VW       = $clog2(line_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
   input  logic          clk_p,
   input  logic          rst,
   input  logic          tick,
   input  logic          hold,
   output logic [HW-1:0] h_cnt,
   output logic [VW-1:0] v_cnt,
   output logic          active,
   output logic          hs_n,
   output logic          vs_n,
   output logic          frame_end
);

   localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic h_wrap;
   logic v_wrap;

   assign h_wrap = (h_cnt == H_LAST);
   assign v_wrap = (v_cnt == V_LAST);

   always_ff @(posedge clk_p) begin
      if (rst || hold) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (tick) begin
         if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= v_wrap ? '0 : v_cnt + VW'(1);
         end else begin
            h_cnt <= h_cnt + HW'(1);
         end
      end
   end

   assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
   assign hs_n      = !((h_cnt >= HS_BEG) && (h_cnt <= HS_END));
   assign vs_n      = !((v_cnt >= VS_BEG) && (v_cnt <= VS_END));
   assign frame_end = h_wrap && v_wrap;

endmodule

// File: rtl/frame_display_reader.sv
// Scans the stored image in raster order and emits a timed RGB pixel stream.
// Define IMG_BORDER_EN to draw a 1-pixel white border right/below the image.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | outputs at reset values, counters held at 0, wait frame_ready
// ST_SCAN | raster scan running; may leave only at a frame boundary
module frame_display_reader
   import frame_display_reader_pkg::*;
#(
   parameter int DATA_WIDTH = PIX_W,
   parameter int ADDR_WIDTH = 19,
   parameter int IMG_W      = IMG_W_DEF,
   parameter int IMG_H      = IMG_H_DEF,
   parameter int H_ACTIVE   = H_ACTIVE_DEF,
   parameter int H_FP       = H_FP_DEF,
   parameter int H_SYNC     = H_SYNC_DEF,
   parameter int H_BP       = H_BP_DEF,
   parameter int V_ACTIVE   = V_ACTIVE_DEF,
   parameter int V_FP       = V_FP_DEF,
   parameter int V_SYNC     = V_SYNC_DEF,
   parameter int V_BP       = V_BP_DEF
) (
   input  logic                  clk_p,
   input  logic                  rst,
   input  logic                  pix_en,
   input  logic                  frame_ready,
   output logic [ADDR_WIDTH-1:0] r_addr,
   input  logic [DATA_WIDTH-1:0] r_data,
   output logic                  hsync,
   output logic                  vsync,
   output logic                  de,
   output logic [DATA_WIDTH-1:0] rgb_out,
   output logic                  frame_start
);

   localparam int HW = $clog2(line_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
   localparam int VW = $clog2(line_total(V_ACTIVE, V_FP, V_SYNC, V_BP));

   localparam logic [HW-1:0] IMG_W_H = HW'(IMG_W);
   localparam logic [VW-1:0] IMG_H_V = VW'(IMG_H);

   generate
      if ((IMG_W > H_ACTIVE) || (IMG_H > V_ACTIVE)) begin : g_bad_geometry
         $error("frame_display_reader: image does not fit inside the active area");
      end
   endgenerate

   rd_state_t state;
   rd_state_t state_nxt;
   logic      scan_on;
   logic      tick;

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          active;
   logic          hs_n;
   logic          vs_n;
   logic          frame_end;

   logic                  in_img;
   logic                  first_pix;
   logic                  border_pix;
   logic [ADDR_WIDTH-1:0] ptr;

   logic in_img_s1;
   logic act_s1;
   logic hs_s1;
   logic vs_s1;
   logic first_s1;
   logic border_s1;

   always_ff @(posedge clk_p) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Leaving SCAN is only decided on the last pixel, so a late drop of
   // frame_ready never cuts a frame short.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (pix_en && frame_ready) state_nxt = ST_SCAN;
         ST_SCAN: if (pix_en && frame_end && !frame_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      scan_on = (state == ST_SCAN);
      tick    = scan_on && pix_en;
   end

   video_timing_gen #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP),
      .HW       (HW),
      .VW       (VW)
   ) u_timing (
      .clk_p     (clk_p),
      .rst       (rst),
      .tick      (tick),
      .hold      (!scan_on),
      .h_cnt     (h_cnt),
      .v_cnt     (v_cnt),
      .active    (active),
      .hs_n      (hs_n),
      .vs_n      (vs_n),
      .frame_end (frame_end)
   );

   assign in_img    = (h_cnt < IMG_W_H) && (v_cnt < IMG_H_V);
   assign first_pix = (h_cnt == '0) && (v_cnt == '0);

`ifdef IMG_BORDER_EN
   assign border_pix = active &&
                       (((h_cnt == IMG_W_H) && (v_cnt <= IMG_H_V)) ||
                        ((v_cnt == IMG_H_V) && (h_cnt <= IMG_W_H)));
`else
   assign border_pix = 1'b0;
`endif

   // Stage 1: address issue plus the per-pixel flags that travel with it.
   always_ff @(posedge clk_p) begin
      if (rst || !scan_on) begin
         ptr       <= '0;
         r_addr    <= '0;
         in_img_s1 <= 1'b0;
         act_s1    <= 1'b0;
         hs_s1     <= 1'b1;
         vs_s1     <= 1'b1;
         first_s1  <= 1'b0;
         border_s1 <= 1'b0;
      end else if (pix_en) begin
         in_img_s1 <= in_img;
         act_s1    <= active;
         hs_s1     <= hs_n;
         vs_s1     <= vs_n;
         first_s1  <= first_pix;
         border_s1 <= border_pix;
         if (in_img) begin
            r_addr <= ptr;
            ptr    <= ptr + ADDR_WIDTH'(1);
         end else if (frame_end) begin
            ptr <= '0;
         end
      end
   end

   // Stage 2: memory data is valid here, one tick after r_addr was issued.
   always_ff @(posedge clk_p) begin
      if (rst || !scan_on) begin
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         de          <= 1'b0;
         rgb_out     <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         if (pix_en) begin
            hsync       <= hs_s1;
            vsync       <= vs_s1;
            de          <= act_s1;
            frame_start <= first_s1;
            if (in_img_s1) begin
               rgb_out <= r_data;
            end else if (border_s1) begin
               rgb_out <= {DATA_WIDTH{1'b1}};
            end else begin
               rgb_out <= '0;
            end
         end
      end
   end

endmodule

// File: doc/frame_display_reader.md
Name: frame_display_reader

Overview:
- Reader end of the processed-image memory that image processing fills via o_addr/data_out/output_valid.
- Once the processor signals all_ready, scans the stored 400x300 RGB444 frame in raster order and drives a VGA-style timed pixel stream (hsync/vsync/de/rgb).
- The image occupies the top-left of the active area; all other active pixels are black.
- Single clock domain. Pixel rate is set by a clock-enable.

Parameters:
- DATA_WIDTH, 12, pixel width (RGB444)
- ADDR_WIDTH, 19, memory read address width
- IMG_W, 400, image width in pixels
- IMG_H, 300, image height in lines
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch

Ports:
- clk_p  in  1  system clock
- rst  in  1  synchronous active-high reset
- pix_en  in  1  pixel tick; all timing advances only when high
- frame_ready  in  1  connect to all_ready; frame memory is complete
- r_addr  out  ADDR_WIDTH  read address to processed-image memory
- r_data  in  DATA_WIDTH  memory data; valid 1 clk after r_addr, held while r_addr stable
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- de  out  1  active-video enable
- rgb_out  out  DATA_WIDTH  pixel colour, 0 when de=0
- frame_start  out  1  one-clk pulse aligned with first output pixel of each frame

Behaviour:
- Reset values: r_addr=0, hsync=1, vsync=1, de=0, rgb_out=0, frame_start=0. Internal h_cnt=v_cnt=0, state=IDLE.
- IDLE: all outputs held at reset values; counters held at 0.
  - Transition to SCAN on the first pix_en tick with frame_ready=1.
- SCAN, on each pix_en tick:
  - h_cnt counts 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - On wrap, v_cnt counts 0..V_TOTAL-1, same formula for vertical.
  - Sync asserted (low) for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; same rule for vertical.
- Frame boundary (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1):
  - frame_ready=1: continue SCAN.
  - frame_ready=0: go to IDLE.
  - frame_ready deasserting mid-frame never truncates the current frame.
- Address generation: incremental, no multiplier.
  - Internal pointer increments on each tick where h_cnt<IMG_W and v_cnt<IMG_H.
  - Pointer resets to 0 at frame start.
  - r_addr is registered from the pointer on the tick. It holds its last value outside the image region, and is 0 at the first image pixel.
- Pipeline, 2 pix_en ticks:
  - Stage 1 registers r_addr plus delayed flags (in_img, active, hs, vs, first).
  - Stage 2 registers the outputs: rgb_out = in_img ? r_data : 0.
  - hsync/vsync/de are delayed identically so they stay aligned with rgb_out.
  - Works for pix_en asserted every clock or sparser.
- frame_start is high for exactly one clk, on the tick where (h_cnt,v_cnt)=(0,0) reaches the output stage.
- Reset mid-frame: all state returns to reset values on the next clk edge; no partial-pixel output afterwards.
- Parameter legality (elaboration check): IMG_W<=H_ACTIVE and IMG_H<=V_ACTIVE.

Optional Feature:
- Macro IMG_BORDER_EN.
- Defined: active pixels with (h_cnt==IMG_W and v_cnt<=IMG_H) or (v_cnt==IMG_H and h_cnt<=IMG_W) output 12'hFFF, producing a 1-pixel white frame right/bottom of the image. The border does not consume addresses.
- Undefined: those pixels output 0.

Decomposition:
- Shared package holds:
  - RGB444 pixel typedef
  - default image-size constants (400, 300, 120000 pixels)
  - 640x480 timing constants
  - derived H_TOTAL/V_TOTAL
- One natural sub-module: video_timing_gen (h/v counters, sync/active flags, frame-end strobe), reused by any future display path.
- Address pointer, pipeline and FSM live in the top module.

Test Plan:
- Use small params (IMG_W=4, IMG_H=3, H_ACTIVE=6, porches 1/2/1, V_ACTIVE=4, porches 1/1/1). Memory model returns r_data=addr. frame_ready=1, pix_en=1 -> first line rgb_out sequence 0,1,2,3,0,0 with de=1 for 6 ticks. frame_start pulses once.
- Same setup, full frame -> addresses 0..11 appear exactly once. Rows 3+ of active area are all 0. hsync low exactly 2 ticks per line, vsync low exactly 1 line per frame.
- pix_en toggling 1-of-3 clocks -> identical output sequence; outputs change only one clk after a pix_en edge.
- frame_ready dropped mid-frame -> current frame completes unchanged, then outputs return to hsync=vsync=1, de=0 and stay idle. Reasserting starts a new frame at address 0.
- rst pulsed mid-line -> next clk: de=0, rgb_out=0, r_addr=0. Restart requires frame_ready.
- IMG_BORDER_EN defined -> pixel (4,0..3) and line 3 cols 0..4 output 12'hFFF; address sequence unchanged.
